if_fetch_buffer: RTL and testbench

Parametrised successor to the single-entry fetch stage. It sits between pre-IF (request issue to inst SRAM) and ID. It tracks up to DEPTH in-flight or buffered fetches in an in-order ring, and captures out-of-band SRAM responses. On flush it discards stale responses by cancel-counting, so pre-IF can redirect immediately without an IF_CANCEL stall. Instruction data reaches ID with zero-cycle bypass on data_ok.

---
 rtl/if_fetch_buffer_if.sv | 37 +++
 rtl/if_fetch_buffer.sv | 123 ++++++++++++
 tb/tb_if_fetch_buffer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_buffer_if.sv
// Bundle of the pre-IF request, inst SRAM response, flush and IF->ID
// signals around the fetch ring. The slave side is the fetch buffer and
// the master side is the surrounding pipeline/SRAM environment.
interface if_fetch_buffer_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int SB_W   = 49
);
    logic              pf_valid;
    logic [PC_W-1:0]   pf_pc;
    logic [SB_W-1:0]   pf_sb;
    logic              pf_allowin;
    logic              inst_sram_data_ok;
    logic [INST_W-1:0] inst_sram_rdata;
    logic              flush;
    logic              id_allowin;
    logic              if_to_id_valid;
    logic [PC_W-1:0]   if_to_id_pc;
    logic [INST_W-1:0] if_to_id_inst;
    logic [SB_W-1:0]   if_to_id_sb;
    logic              cancel_pending;
    logic              err_spurious;

    modport master (
        output pf_valid, pf_pc, pf_sb, inst_sram_data_ok, inst_sram_rdata,
               flush, id_allowin,
        input  pf_allowin, if_to_id_valid, if_to_id_pc, if_to_id_inst,
               if_to_id_sb, cancel_pending, err_spurious
    );

    modport slave (
        input  pf_valid, pf_pc, pf_sb, inst_sram_data_ok, inst_sram_rdata,
               flush, id_allowin,
        output pf_allowin, if_to_id_valid, if_to_id_pc, if_to_id_inst,
               if_to_id_sb, cancel_pending, err_spurious
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// In-order fetch ring between pre-IF and ID. Entries are allocated when
// the SRAM accepts a request, filled by in-order data_ok responses and
// popped by ID. A flush empties the ring and converts every response still
// owed by the SRAM into a discard credit, so pre-IF can redirect at once.
module if_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int SB_W   = 49
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] CAP     = (AW+2)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]       wptr_q, fptr_q, rptr_q, disc_q;
    logic [DEPTH-1:0]  valid_q, filled_q;
    logic              err_q;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [SB_W-1:0]   sb_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [AW:0]   occ, unfilled, disc_flush;
    logic [AW-1:0] widx, fidx, ridx;
    logic          allowin, issue, alloc, disc_take, fill, spurious;
    logic          bypass, head_ready, pop;

    assign widx = wptr_q[AW-1:0];
    assign fidx = fptr_q[AW-1:0];
    assign ridx = rptr_q[AW-1:0];

    assign occ      = wptr_q - rptr_q;
    assign unfilled = wptr_q - fptr_q;

    // Every entry and every discard credit stands for one response the
    // SRAM still owes or one buffered instruction; together they must fit.
    assign allowin = ({1'b0, occ} + {1'b0, disc_q}) < CAP;

    assign issue     = bus.pf_valid && allowin;
    assign alloc     = issue && !bus.flush;
    // Discard credits always absorb the oldest responses first.
    assign disc_take = bus.inst_sram_data_ok && (disc_q != '0);
    assign fill      = bus.inst_sram_data_ok && (disc_q == '0) && (unfilled != '0);
    assign spurious  = bus.inst_sram_data_ok && (disc_q == '0) && (unfilled == '0);
    assign bypass    = fill && (fptr_q == rptr_q);

    assign head_ready = valid_q[ridx] && (filled_q[ridx] || bypass);
    assign pop        = head_ready && bus.id_allowin && !bus.flush;

    // Responses owed after a flush: old credits, unfilled entries and the
    // request accepted in the flush cycle, minus the one answered now.
    assign disc_flush = disc_q + unfilled + (AW+1)'(issue) - (AW+1)'(disc_take || fill);

    assign bus.pf_allowin     = allowin;
    assign bus.if_to_id_valid = head_ready;
    assign bus.if_to_id_pc    = pc_mem[ridx];
    assign bus.if_to_id_sb    = sb_mem[ridx];
    assign bus.if_to_id_inst  = bypass ? bus.inst_sram_rdata : inst_mem[ridx];
    assign bus.cancel_pending = (disc_q != '0);
    assign bus.err_spurious   = err_q;

    // Payload storage; the fill write happens even when the entry is
    // bypassed and popped in the same cycle.
    // NOTE: payload arrays have no reset; valid/filled bits gate every use.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem[widx] <= bus.pf_pc;
            sb_mem[widx] <= bus.pf_sb;
        end
        if (fill) begin
            inst_mem[fidx] <= bus.inst_sram_rdata;
        end
    end

    // Ring pointers, per-entry status, discard counter and sticky error.
    // NOTE: state uses non-blocking assignments; later writes to the same
    // status bit in this block win, so pop clears after a same-cycle fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            fptr_q   <= '0;
            rptr_q   <= '0;
            disc_q   <= '0;
            valid_q  <= '0;
            filled_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (spurious) begin
                err_q <= 1'b1;
            end
            if (bus.flush) begin
                valid_q  <= '0;
                filled_q <= '0;
                rptr_q   <= wptr_q;
                fptr_q   <= wptr_q;
                disc_q   <= disc_flush;
            end else begin
                if (disc_take) begin
                    disc_q <= disc_q - PTR_ONE;
                end
                if (fill) begin
                    filled_q[fidx] <= 1'b1;
                    fptr_q         <= fptr_q + PTR_ONE;
                end
                if (pop) begin
                    valid_q[ridx]  <= 1'b0;
                    filled_q[ridx] <= 1'b0;
                    rptr_q         <= rptr_q + PTR_ONE;
                end
                if (alloc) begin
                    valid_q[widx]  <= 1'b1;
                    filled_q[widx] <= 1'b0;
                    wptr_q         <= wptr_q + PTR_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: directed scenarios followed by random traffic
// compared against a queue-based model of outstanding fetches.
module tb_if_fetch_buffer;
    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int SB_W   = 49;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_fetch_buffer_if #(.PC_W(PC_W), .INST_W(INST_W), .SB_W(SB_W)) bus ();

    if_fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .SB_W(SB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [SB_W-1:0]   sb;
        logic [INST_W-1:0] inst;
        bit                filled;
    } entry_t;

    entry_t mq[$];   // fetches in program order, oldest first
    int     m_disc;  // responses still owed for flushed fetches
    bit     m_err;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_clear();
        mq.delete();
        m_disc = 0;
        m_err  = 1'b0;
    endfunction

    function automatic int m_unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    function automatic bit m_allowin();
        return (mq.size() + m_disc) < DEPTH;
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
        if (mq[0].filled) return 1'b1;
        return bus.inst_sram_data_ok && (m_disc == 0);
    endfunction

    function automatic logic [INST_W-1:0] m_inst();
        return mq[0].filled ? mq[0].inst : bus.inst_sram_rdata;
    endfunction

    function automatic logic [SB_W-1:0] sb_of(input logic [PC_W-1:0] pc);
        return {pc[16:0], ~pc};
    endfunction

    task automatic set_idle();
        bus.pf_valid          = 1'b0;
        bus.pf_pc             = '0;
        bus.pf_sb             = '0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = '0;
        bus.flush             = 1'b0;
        bus.id_allowin        = 1'b0;
    endtask

    // Apply one cycle of inputs after the falling edge, then settle.
    task automatic drive(input bit pv, input logic [PC_W-1:0] pc, input logic [SB_W-1:0] sb,
                         input bit dok, input logic [INST_W-1:0] rd, input bit fl, input bit ida);
        @(negedge clk);
        bus.pf_valid          = pv;
        bus.pf_pc             = pc;
        bus.pf_sb             = sb;
        bus.inst_sram_data_ok = dok;
        bus.inst_sram_rdata   = rd;
        bus.flush             = fl;
        bus.id_allowin        = ida;
        #1;
    endtask

    // Advance through the rising edge and apply the same cycle to the model.
    task automatic tick();
        bit     issue;
        bit     pop;
        int     idx;
        entry_t e;
        issue = bus.pf_valid && m_allowin();
        pop   = m_valid() && bus.id_allowin && !bus.flush;
        @(posedge clk);
        if (bus.inst_sram_data_ok) begin
            if (m_disc > 0) begin
                m_disc--;
            end else begin
                idx = -1;
                foreach (mq[i]) if (!mq[i].filled && idx < 0) idx = i;
                if (idx >= 0) begin
                    mq[idx].filled = 1'b1;
                    mq[idx].inst   = bus.inst_sram_rdata;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (bus.flush) begin
            m_disc += m_unfilled() + int'(issue);
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (issue) begin
                e.pc = bus.pf_pc; e.sb = bus.pf_sb; e.inst = '0; e.filled = 1'b0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        #1;
        n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.if_to_id_valid); end
        n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b want 1", bus.pf_allowin); end
        n_checks++; if (bus.cancel_pending !== 1'b0) begin n_fail++; $display("FAIL reset_cancel: got %b want 0", bus.cancel_pending); end
        n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_spurious); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_bypass_stream();
        logic [PC_W-1:0] pc, epc;
        for (int c = 0; c < 6; c++) begin
            pc  = 32'h1C00_0000 + 32'(4 * c);
            epc = 32'h1C00_0000 + 32'(4 * (c - 2));
            drive(c < 4, pc, sb_of(pc), c >= 2, 32'hA000_0000 + 32'(c - 2), 1'b0, 1'b1);
            n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL bypass_allowin c%0d: got %b want 1", c, bus.pf_allowin); end
            if (c >= 2) begin
                n_checks++; if (bus.if_to_id_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid c%0d: got %b want 1", c, bus.if_to_id_valid); end
                n_checks++; if (bus.if_to_id_pc !== epc) begin n_fail++; $display("FAIL bypass_pc c%0d: got %h want %h", c, bus.if_to_id_pc, epc); end
                n_checks++; if (bus.if_to_id_inst !== 32'hA000_0000 + 32'(c - 2)) begin n_fail++; $display("FAIL bypass_inst c%0d: got %h want %h", c, bus.if_to_id_inst, 32'hA000_0000 + 32'(c - 2)); end
            end else begin
                n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_idle c%0d: got %b want 0", c, bus.if_to_id_valid); end
            end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        logic [PC_W-1:0] pc, epc;
        for (int c = 0; c < 10; c++) begin
            pc  = 32'h1C00_0100 + 32'(4 * c);
            epc = 32'h1C00_0100 + 32'(4 * (c - 5));
            drive(c < 4, pc, sb_of(pc), (c >= 1) && (c <= 4), 32'hB000_0000 + 32'(c - 1), 1'b0, c >= 5);
            if (c == 4) begin
                n_checks++; if (bus.pf_allowin !== 1'b0) begin n_fail++; $display("FAIL drain_full_allowin: got %b want 0", bus.pf_allowin); end
            end
            if (c >= 5 && c <= 8) begin
                n_checks++; if (bus.if_to_id_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid c%0d: got %b want 1", c, bus.if_to_id_valid); end
                n_checks++; if (bus.if_to_id_pc !== epc) begin n_fail++; $display("FAIL drain_pc c%0d: got %h want %h", c, bus.if_to_id_pc, epc); end
                n_checks++; if (bus.if_to_id_inst !== 32'hB000_0000 + 32'(c - 5)) begin n_fail++; $display("FAIL drain_inst c%0d: got %h want %h", c, bus.if_to_id_inst, 32'hB000_0000 + 32'(c - 5)); end
            end
            if (c == 9) begin
                n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b want 0", bus.if_to_id_valid); end
                n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL drain_empty_allowin: got %b want 1", bus.pf_allowin); end
            end
            tick();
        end
    endtask

    task automatic test_flush_discard();
        logic [PC_W-1:0] pc;
        for (int c = 0; c < 10; c++) begin
            pc = (c == 8) ? 32'h1C00_1000 : 32'h1C00_0200 + 32'(4 * c);
            drive((c <= 3) || (c == 8), pc, sb_of(pc), (c >= 4 && c <= 7) || (c == 9),
                  (c == 9) ? 32'h1234_5678 : 32'hDEAD_0000 + 32'(c), c == 3, 1'b1);
            if (c == 3) begin
                n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_allowin: got %b want 1", bus.pf_allowin); end
            end
            if (c == 4) begin
                n_checks++; if (bus.pf_allowin !== 1'b0) begin n_fail++; $display("FAIL disc4_allowin: got %b want 0", bus.pf_allowin); end
            end
            if (c >= 4 && c <= 7) begin
                n_checks++; if (bus.cancel_pending !== 1'b1) begin n_fail++; $display("FAIL discard_cancel c%0d: got %b want 1", c, bus.cancel_pending); end
                n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL discard_valid c%0d: got %b want 0", c, bus.if_to_id_valid); end
            end
            if (c == 8) begin
                n_checks++; if (bus.cancel_pending !== 1'b0) begin n_fail++; $display("FAIL discard_done_cancel: got %b want 0", bus.cancel_pending); end
                n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL discard_done_allowin: got %b want 1", bus.pf_allowin); end
            end
            if (c == 9) begin
                n_checks++; if (bus.if_to_id_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_valid: got %b want 1", bus.if_to_id_valid); end
                n_checks++; if (bus.if_to_id_pc !== 32'h1C00_1000) begin n_fail++; $display("FAIL redirect_pc: got %h want 1c001000", bus.if_to_id_pc); end
                n_checks++; if (bus.if_to_id_inst !== 32'h1234_5678) begin n_fail++; $display("FAIL redirect_inst: got %h want 12345678", bus.if_to_id_inst); end
            end
            tick();
        end
    endtask

    task automatic test_flush_fill();
        logic [PC_W-1:0] pc;
        for (int c = 0; c < 6; c++) begin
            pc = 32'h1C00_0300 + 32'(4 * c);
            drive(c <= 2, pc, sb_of(pc), (c >= 2) && (c <= 4), 32'h0000_0055 + 32'(c), c == 2, 1'b1);
            if (c == 3) begin
                n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL flushfill_valid: got %b want 0", bus.if_to_id_valid); end
                n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL flushfill_allowin: got %b want 1", bus.pf_allowin); end
            end
            if (c == 3 || c == 4) begin
                n_checks++; if (bus.cancel_pending !== 1'b1) begin n_fail++; $display("FAIL flushfill_cancel c%0d: got %b want 1", c, bus.cancel_pending); end
            end
            if (c == 5) begin
                n_checks++; if (bus.cancel_pending !== 1'b0) begin n_fail++; $display("FAIL flushfill_done_cancel: got %b want 0", bus.cancel_pending); end
                n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL flushfill_done_valid: got %b want 0", bus.if_to_id_valid); end
                n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL flushfill_err: got %b want 0", bus.err_spurious); end
            end
            tick();
        end
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, '0, c == 1, 32'hFFFF_0000, 1'b0, 1'b1);
            if (c <= 1) begin
                n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL spurious_pre_err c%0d: got %b want 0", c, bus.err_spurious); end
            end else begin
                n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL spurious_err c%0d: got %b want 1", c, bus.err_spurious); end
                n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL spurious_allowin c%0d: got %b want 1", c, bus.pf_allowin); end
            end
            n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL spurious_valid c%0d: got %b want 0", c, bus.if_to_id_valid); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [PC_W-1:0] pc;
        for (int c = 0; c < 3; c++) begin
            pc = 32'h1C00_0400 + 32'(4 * c);
            drive(1'b1, pc, sb_of(pc), c >= 1, 32'h0000_00C0 + 32'(c), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.if_to_id_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", bus.if_to_id_valid); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", bus.if_to_id_valid); end
        n_checks++; if (bus.pf_allowin !== 1'b1) begin n_fail++; $display("FAIL async_reset_allowin: got %b want 1", bus.pf_allowin); end
        n_checks++; if (bus.cancel_pending !== 1'b0) begin n_fail++; $display("FAIL async_reset_cancel: got %b want 0", bus.cancel_pending); end
        n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL async_reset_err: got %b want 0", bus.err_spurious); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        drive(1'b0, '0, '0, 1'b1, 32'h0000_00C2, 1'b0, 1'b1);
        n_checks++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL stale_valid: got %b want 0", bus.if_to_id_valid); end
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL stale_err: got %b want 1", bus.err_spurious); end
        tick();
    endtask

    task automatic test_random();
        bit pv, dok, fl, ida;
        logic [SB_W-1:0] sb;
        for (int c = 0; c < 800; c++) begin
            pv  = $urandom_range(0, 99) < 60;
            dok = (m_disc + m_unfilled() > 0) && ($urandom_range(0, 99) < 55);
            fl  = $urandom_range(0, 99) < 6;
            ida = $urandom_range(0, 99) < 70;
            sb  = SB_W'({$urandom(), $urandom()});
            drive(pv, $urandom(), sb, dok, $urandom(), fl, ida);
            n_checks++; if (bus.pf_allowin !== m_allowin()) begin n_fail++; $display("FAIL rand_allowin c%0d: got %b want %b", c, bus.pf_allowin, m_allowin()); end
            n_checks++; if (bus.if_to_id_valid !== m_valid()) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.if_to_id_valid, m_valid()); end
            n_checks++; if (bus.cancel_pending !== (m_disc > 0)) begin n_fail++; $display("FAIL rand_cancel c%0d: got %b want %b", c, bus.cancel_pending, m_disc > 0); end
            n_checks++; if (bus.err_spurious !== m_err) begin n_fail++; $display("FAIL rand_err c%0d: got %b want %b", c, bus.err_spurious, m_err); end
            if (m_valid()) begin
                n_checks++; if (bus.if_to_id_pc !== mq[0].pc) begin n_fail++; $display("FAIL rand_pc c%0d: got %h want %h", c, bus.if_to_id_pc, mq[0].pc); end
                n_checks++; if (bus.if_to_id_sb !== mq[0].sb) begin n_fail++; $display("FAIL rand_sb c%0d: got %h want %h", c, bus.if_to_id_sb, mq[0].sb); end
                n_checks++; if (bus.if_to_id_inst !== m_inst()) begin n_fail++; $display("FAIL rand_inst c%0d: got %h want %h", c, bus.if_to_id_inst, m_inst()); end
            end
            tick();
        end
    endtask

    initial begin
        set_idle();
        model_clear();
        test_reset();
        test_bypass_stream();
        test_fill_drain();
        test_flush_discard();
        test_flush_fill();
        test_spurious();
        test_async_reset();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
